simon_sequence_player: RTL

- Plays back the stored Simon colour sequence on the four game LEDs, one step per timing window.
- Sits directly downstream of the 1 Hz rate divider and consumes its single-cycle `tick` pulse as the time base.
- The game controller loads colours through a write port, then issues `start`. The block lights each colour for ON_TICKS ticks and blanks for GAP_TICKS ticks, then reports `done`.

---
 rtl/simon_sequence_player_if.sv | 44 ++++
 rtl/simon_sequence_player.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/simon_sequence_player_if.sv
// ----------------------------------------------------------------------------
// simon_sequence_player_if
//   Bundles the control, storage-write and status signals of the Simon
//   sequence player. The game controller side uses the master modport; the
//   player itself uses the slave modport.
//
//   Signals:
//     tick     one-cycle time-base pulse from the rate divider
//     wr_en    write a colour into sequence storage
//     wr_addr  storage write address
//     wr_data  colour code (0=green, 1=red, 2=yellow, 3=blue)
//     start    one-cycle pulse, begin playback
//     length   number of steps to play (clamped to storage depth)
//     abort    stop playback and return to idle
//     led      one-hot lit colour, 0 = dark
//     step     index of the step currently shown
//     busy     playback in progress
//     done     one-cycle pulse at the end of a completed playback
// ----------------------------------------------------------------------------
interface simon_sequence_player_if #(
    parameter int ADDR_W = 5
);
    logic              tick;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        wr_data;
    logic              start;
    logic [ADDR_W:0]   length;
    logic              abort;
    logic [3:0]        led;
    logic [ADDR_W-1:0] step;
    logic              busy;
    logic              done;

    modport master (
        output tick, wr_en, wr_addr, wr_data, start, length, abort,
        input  led, step, busy, done
    );

    modport slave (
        input  tick, wr_en, wr_addr, wr_data, start, length, abort,
        output led, step, busy, done
    );
endinterface

// File: rtl/simon_sequence_player.sv
// ----------------------------------------------------------------------------
// simon_sequence_player
//   Plays the stored Simon colour sequence on the four game LEDs. Each step
//   lights its colour for ON_TICKS ticks of the rate divider, then blanks for
//   GAP_TICKS ticks. Playback waits for the first tick after start so the
//   first colour gets a full window. A one-cycle done pulse marks the end.
//
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    slave side of simon_sequence_player_if (tick, storage write
//            port, start/length/abort controls, led/step/busy/done status)
//
//   Parameters:
//     MAX_LEN    storage depth (2**ADDR_W)
//     ADDR_W     storage address width
//     ON_TICKS   ticks each colour stays lit (1..15)
//     GAP_TICKS  ticks of blank between steps (1..15)
// ----------------------------------------------------------------------------
module simon_sequence_player #(
    parameter int MAX_LEN   = 32,
    parameter int ADDR_W    = 5,
    parameter int ON_TICKS  = 1,
    parameter int GAP_TICKS = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    simon_sequence_player_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        SHOW,
        GAP,
        DONE
    } state_t;

    localparam logic [3:0]      ON_LAST   = 4'(ON_TICKS - 1);
    localparam logic [3:0]      GAP_LAST  = 4'(GAP_TICKS - 1);
    localparam logic [ADDR_W:0] MAX_LEN_W = (ADDR_W + 1)'(MAX_LEN);
    localparam logic [ADDR_W:0] LEN_ONE   = (ADDR_W + 1)'(1);

    // Sequence storage; intentionally not reset.
    logic [1:0] r_mem [MAX_LEN];

    state_t            r_state, w_state_nxt;
    logic [ADDR_W:0]   r_len,   w_len_nxt;
    logic [ADDR_W-1:0] r_step,  w_step_nxt;
    logic [3:0]        r_cnt,   w_cnt_nxt;
    logic [3:0]        r_led,   w_led_nxt;
    logic              r_busy,  w_busy_nxt;
    logic              r_done,  w_done_nxt;

    logic [ADDR_W:0]   w_len_clamp;
    logic [ADDR_W-1:0] w_step_inc;
    logic [3:0]        w_cnt_inc;
    logic              w_last_step;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    assign w_len_clamp = (bus.length > MAX_LEN_W) ? MAX_LEN_W : bus.length;
    assign w_step_inc  = r_step + ADDR_W'(1);
    // Saturate rather than wrap so a mis-set terminal count can never alias.
    assign w_cnt_inc   = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
    assign w_last_step = ({1'b0, r_step} == (r_len - LEN_ONE));

    // Writes only land while idle, so playback reads never race a write.
    always_ff @(posedge clk) begin
        if (bus.wr_en && (r_state == IDLE)) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_step  <= '0;
            r_cnt   <= '0;
            r_led   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_step  <= w_step_nxt;
            r_cnt   <= w_cnt_nxt;
            r_led   <= w_led_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_step_nxt  = r_step;
        w_cnt_nxt   = r_cnt;
        w_led_nxt   = r_led;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        if ((r_state != IDLE) && bus.abort) begin
            // Abort beats tick and suppresses done.
            w_state_nxt = IDLE;
            w_led_nxt   = 4'b0000;
            w_busy_nxt  = 1'b0;
            w_cnt_nxt   = 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    // A tick in this cycle is deliberately ignored: the
                    // first colour waits for the next tick in ALIGN.
                    if (bus.start) begin
                        w_len_nxt   = w_len_clamp;
                        w_step_nxt  = '0;
                        w_cnt_nxt   = 4'd0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = ALIGN;
                    end
                end
                ALIGN: begin
                    // Zero length is resolved from the latched length, so
                    // busy is visible for one cycle before done.
                    if (r_len == '0) begin
                        w_state_nxt = DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else if (bus.tick) begin
                        w_state_nxt = SHOW;
                        w_led_nxt   = onehot(r_mem[r_step]);
                        w_cnt_nxt   = 4'd0;
                    end
                end
                SHOW: begin
                    if (bus.tick) begin
                        if (r_cnt == ON_LAST) begin
                            w_state_nxt = GAP;
                            w_led_nxt   = 4'b0000;
                            w_cnt_nxt   = 4'd0;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end
                end
                GAP: begin
                    if (bus.tick) begin
                        if (r_cnt == GAP_LAST) begin
                            w_cnt_nxt = 4'd0;
                            if (w_last_step) begin
                                w_state_nxt = DONE;
                                w_busy_nxt  = 1'b0;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = SHOW;
                                w_step_nxt  = w_step_inc;
                                w_led_nxt   = onehot(r_mem[w_step_inc]);
                            end
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end
                end
                DONE: begin
                    // done/busy were set on entry; this cycle is the pulse.
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.led  = r_led;
    assign bus.step = r_step;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule
